// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and helpers for the N-port RW memory
package mem_pkg;

  localparam int MAX_PORTS      = 8;
  localparam int DEF_WORD_BYTES = 8;
  localparam int DATA_W         = 8 * DEF_WORD_BYTES;

  function automatic bit rd_latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  // Candidate vector holds one bit per port that writes this byte of this address;
  // the lowest-index candidate keeps the byte.
  function automatic logic [MAX_PORTS-1:0] byte_winner(input logic [MAX_PORTS-1:0] cand);
    return cand & (~cand + MAX_PORTS'(1));
  endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// rtl/mem_rd_pipe.sv - LATENCY-deep {valid, err, data} read stage; data holds while not valid
module mem_rd_pipe
  import mem_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_err;
  logic [DATA_W-1:0]  r_data [LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int k = 0; k < LATENCY; k++) r_data[k] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_err[0]   <= i_err;
      if (i_valid) r_data[0] <= i_data;
      for (int k = 1; k < LATENCY; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_err[k]   <= r_err[k-1];
        if (r_valid[k-1]) r_data[k] <= r_data[k-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_err   = r_err[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/mem_nrw_pipe.sv
// rtl/mem_nrw_pipe.sv - N-port RW memory with byte enables, collision arbitration and range check
// Define MEM_WR_FWD_EN for write-first reads; default build is read-first.
module mem_nrw_pipe
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int WORD_BYTES = 8,
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [NUM_PORTS-1:0]              i_re,
  input  logic [NUM_PORTS-1:0]              i_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_addr,
  input  logic [NUM_PORTS*8*WORD_BYTES-1:0] i_wr_data,
  input  logic [NUM_PORTS*WORD_BYTES-1:0]   i_be,
  output logic [NUM_PORTS*8*WORD_BYTES-1:0] o_rd_data,
  output logic [NUM_PORTS-1:0]              o_rd_valid,
  output logic [NUM_PORTS-1:0]              o_addr_err,
  output logic                              o_wr_coll
);

  localparam int DW  = 8 * WORD_BYTES;
  localparam int AW1 = ADDR_WIDTH + 1;

  if (!rd_latency_legal(RD_LATENCY)) begin : g_bad_latency
    $error("mem_nrw_pipe: RD_LATENCY must be 1 or 2");
  end

  logic [DW-1:0]         r_mem [0:MEM_DEPTH-1];
  logic                  r_coll;
  logic [ADDR_WIDTH-1:0] w_addr [NUM_PORTS];
  logic [NUM_PORTS-1:0]  w_in_range;
  logic [NUM_PORTS-1:0]  w_wr_ok;
  logic [NUM_PORTS-1:0]  w_err_in;
  logic [WORD_BYTES-1:0] w_win [NUM_PORTS];
  logic [DW-1:0]         w_rd_word [NUM_PORTS];
  logic                  w_coll;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port_dec
    assign w_addr[gp]     = i_addr[gp*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_in_range[gp] = {1'b0, w_addr[gp]} < AW1'(MEM_DEPTH);
    assign w_wr_ok[gp]    = i_we[gp] & w_in_range[gp];
    assign w_err_in[gp]   = (i_re[gp] | i_we[gp]) & ~w_in_range[gp];
  end

  always_comb begin
    logic [MAX_PORTS-1:0] cand;
    logic [MAX_PORTS-1:0] win;
    w_win  = '{default: '0};
    w_coll = 1'b0;
    cand   = '0;
    win    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        cand = '0;
        for (int q = 0; q < NUM_PORTS; q++)
          cand[q] = w_wr_ok[q] & i_be[q*WORD_BYTES + b] & (w_addr[q] == w_addr[p]);
        win         = byte_winner(cand);
        w_win[p][b] = win[p];
      end
      for (int q = p + 1; q < NUM_PORTS; q++)
        if (w_wr_ok[p] && w_wr_ok[q] && (w_addr[p] == w_addr[q]) &&
            ((i_be[p*WORD_BYTES +: WORD_BYTES] & i_be[q*WORD_BYTES +: WORD_BYTES]) != '0))
          w_coll = 1'b1;
    end
  end

  always_comb begin
    w_rd_word = '{default: '0};
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (w_in_range[p]) w_rd_word[p] = r_mem[w_addr[p]];
`ifdef MEM_WR_FWD_EN
      // Bypass: bytes won by a same-cycle write to this address replace the stored bytes.
      for (int b = 0; b < WORD_BYTES; b++)
        for (int q = 0; q < NUM_PORTS; q++)
          if (w_win[q][b] && (w_addr[q] == w_addr[p]))
            w_rd_word[p][b*8 +: 8] = i_wr_data[q*DW + b*8 +: 8];
`else
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int p = 0; p < NUM_PORTS; p++)
        for (int b = 0; b < WORD_BYTES; b++)
          if (w_win[p][b]) r_mem[w_addr[p]][b*8 +: 8] <= i_wr_data[p*DW + b*8 +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_coll <= 1'b0;
    else       r_coll <= w_coll;
  end

  assign o_wr_coll = r_coll;

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_rd
    mem_rd_pipe #(
      .DATA_W (DW),
      .LATENCY(RD_LATENCY)
    ) u_rd_pipe (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_valid(i_re[gp]),
      .i_err  (w_err_in[gp]),
      .i_data (w_rd_word[gp]),
      .o_valid(o_rd_valid[gp]),
      .o_err  (o_addr_err[gp]),
      .o_data (o_rd_data[gp*DW +: DW])
    );
  end

endmodule

// File: tb/tb_mem_nrw_pipe.sv
// tb/tb_mem_nrw_pipe.sv - self-checking bench for mem_nrw_pipe (latency-1/depth-256 and latency-2/depth-200 instances)
module tb_mem_nrw_pipe;

  localparam int NP = 2;
  localparam int AW = 8;
  localparam int WB = 8;
  localparam int DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic [NP-1:0]      re, we;
  logic [NP*AW-1:0]   addr;
  logic [NP*DW-1:0]   wdata;
  logic [NP*WB-1:0]   be;
  logic [NP*DW-1:0]   rd_data0, rd_data1;
  logic [NP-1:0]      rv0, rv1, ae0, ae1;
  logic               coll0, coll1;

  mem_nrw_pipe #(.ADDR_WIDTH(AW), .MEM_DEPTH(256), .WORD_BYTES(WB), .NUM_PORTS(NP), .RD_LATENCY(1)) dut_l1 (
    .i_clk(clk), .i_rst(rst), .i_re(re), .i_we(we), .i_addr(addr), .i_wr_data(wdata), .i_be(be),
    .o_rd_data(rd_data0), .o_rd_valid(rv0), .o_addr_err(ae0), .o_wr_coll(coll0));

  mem_nrw_pipe #(.ADDR_WIDTH(AW), .MEM_DEPTH(200), .WORD_BYTES(WB), .NUM_PORTS(NP), .RD_LATENCY(2)) dut_l2 (
    .i_clk(clk), .i_rst(rst), .i_re(re), .i_we(we), .i_addr(addr), .i_wr_data(wdata), .i_be(be),
    .o_rd_data(rd_data1), .o_rd_valid(rv1), .o_addr_err(ae1), .o_wr_coll(coll1));

  // Reference model: per-instance word array plus expected visible outputs.
  logic [63:0] mm [2][256];
  logic [1:0]  ev [2];
  logic [1:0]  ee [2];
  logic [63:0] ed [2][2];
  logic        ec [2];
  logic [1:0]  pv, pe;
  logic [63:0] pd [2];

  int passed = 0;
  int total  = 0;

  task automatic idle();
    re = '0; we = '0; addr = '0; wdata = '0; be = '0;
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input int a, input logic [63:0] d, input logic [7:0] b);
    re[p] = r;
    we[p] = w;
    addr[p*AW +: AW] = a[7:0];
    wdata[p*DW +: DW] = d;
    be[p*WB +: WB] = b;
  endtask

  task automatic model_edge(input int d, input int lat, input int depth);
    logic [63:0] rdat [2];
    logic [1:0]  rvv, rerr, ok;
    int          a [2];
    logic        cl;
    if (rst) begin
      ev[d] = '0; ee[d] = '0; ec[d] = 1'b0; ed[d][0] = '0; ed[d][1] = '0;
      if (lat == 2) begin pv = '0; pe = '0; pd[0] = '0; pd[1] = '0; end
      return;
    end
    for (int p = 0; p < NP; p++) begin
      a[p]    = int'(addr[p*AW +: AW]);
      ok[p]   = a[p] < depth;
      rvv[p]  = re[p];
      rerr[p] = (re[p] | we[p]) & ~ok[p];
      rdat[p] = ok[p] ? mm[d][a[p]] : 64'h0;
    end
    cl = we[0] && we[1] && ok[0] && ok[1] && (a[0] == a[1]) && ((be[7:0] & be[15:8]) != 8'h00);
    // Apply highest port first so the lowest port's bytes are the ones left standing.
    for (int p = NP - 1; p >= 0; p--)
      if (we[p] && ok[p])
        for (int b = 0; b < WB; b++)
          if (be[p*WB + b]) mm[d][a[p]][b*8 +: 8] = wdata[p*DW + b*8 +: 8];
`ifdef MEM_WR_FWD_EN
    for (int p = 0; p < NP; p++) rdat[p] = ok[p] ? mm[d][a[p]] : 64'h0;
`endif
    if (lat == 1) begin
      ev[d] = rvv; ee[d] = rerr;
      for (int p = 0; p < NP; p++) if (rvv[p]) ed[d][p] = rdat[p];
    end else begin
      ev[d] = pv; ee[d] = pe;
      for (int p = 0; p < NP; p++) if (pv[p]) ed[d][p] = pd[p];
      pv = rvv; pe = rerr; pd[0] = rdat[0]; pd[1] = rdat[1];
    end
    ec[d] = cl;
  endtask

  task automatic step();
    model_edge(0, 1, 256);
    model_edge(1, 2, 200);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++;
    if ({rv0, ae0, coll0, rd_data0} !== '0) $display("FAIL reset_l1 act=%h exp=0", {rv0, ae0, coll0, rd_data0});
    else passed++;
    total++;
    if ({rv1, ae1, coll1, rd_data1} !== '0) $display("FAIL reset_l2 act=%h exp=0", {rv1, ae1, coll1, rd_data1});
    else passed++;
  endtask

  task automatic preload();
    for (int a = 0; a < 256; a++) begin
      idle();
      set_port(0, 1'b0, 1'b1, a, {$urandom, $urandom}, 8'hFF);
      step();
    end
    idle();
  endtask

  task automatic test_write_read();
    idle(); set_port(0, 1'b0, 1'b1, 'h05, 64'h1122334455667788, 8'hFF); step();
    idle(); set_port(1, 1'b1, 1'b0, 'h05, 64'h0, 8'h00); step();
    total++;
    if (rv0[1] !== 1'b1 || rd_data0[DW +: DW] !== 64'h1122334455667788)
      $display("FAIL wr_rd_l1 act=%b/%h exp=1/1122334455667788", rv0[1], rd_data0[DW +: DW]);
    else passed++;
    total++;
    if (rv1 !== 2'b00) $display("FAIL wr_rd_l2_early act=%b exp=00", rv1);
    else passed++;
    idle(); step();
    total++;
    if (rv1[1] !== 1'b1 || rd_data1[DW +: DW] !== 64'h1122334455667788)
      $display("FAIL wr_rd_l2 act=%b/%h exp=1/1122334455667788", rv1[1], rd_data1[DW +: DW]);
    else passed++;
    total++;
    if (rv0 !== 2'b00 || rd_data0[DW +: DW] !== 64'h1122334455667788)
      $display("FAIL wr_rd_hold act=%b/%h exp=00/1122334455667788", rv0, rd_data0[DW +: DW]);
    else passed++;
  endtask

  task automatic test_collision();
    idle();
    set_port(0, 1'b0, 1'b1, 'h10, {8{8'hAA}}, 8'h0F);
    set_port(1, 1'b0, 1'b1, 'h10, {8{8'hBB}}, 8'hFC);
    step();
    total++;
    if (coll0 !== 1'b1 || coll1 !== 1'b1) $display("FAIL coll_flag act=%b%b exp=11", coll0, coll1);
    else passed++;
    idle(); set_port(0, 1'b1, 1'b0, 'h10, 64'h0, 8'h00); step();
    total++;
    if (coll0 !== 1'b0 || rd_data0[0 +: DW] !== 64'hBBBBBBBBAAAAAAAA)
      $display("FAIL coll_merge_l1 act=%b/%h exp=0/bbbbbbbbaaaaaaaa", coll0, rd_data0[0 +: DW]);
    else passed++;
    idle(); step();
    total++;
    if (rd_data1[0 +: DW] !== 64'hBBBBBBBBAAAAAAAA)
      $display("FAIL coll_merge_l2 act=%h exp=bbbbbbbbaaaaaaaa", rd_data1[0 +: DW]);
    else passed++;
    // Disjoint masks on the same address: merge without a collision flag.
    idle();
    set_port(0, 1'b0, 1'b1, 'h11, {8{8'h11}}, 8'h0F);
    set_port(1, 1'b0, 1'b1, 'h11, {8{8'h22}}, 8'hF0);
    step();
    total++;
    if (coll0 !== 1'b0 || coll1 !== 1'b0) $display("FAIL coll_disjoint act=%b%b exp=00", coll0, coll1);
    else passed++;
    idle(); set_port(1, 1'b1, 1'b0, 'h11, 64'h0, 8'h00); step();
    total++;
    if (rd_data0[DW +: DW] !== 64'h2222222211111111)
      $display("FAIL coll_disjoint_data act=%h exp=2222222211111111", rd_data0[DW +: DW]);
    else passed++;
    idle(); step();
  endtask

  task automatic test_pipelined();
    for (int k = 0; k < 6; k++) begin
      idle();
      if (k < 4) set_port(0, 1'b1, 1'b0, k, 64'h0, 8'h00);
      step();
      total++;
      if (rv0[0] !== (k < 4) || rv1[0] !== (k >= 1 && k <= 4) ||
          (k >= 1 && k <= 4 && rd_data1[0 +: DW] !== mm[1][k-1]))
        $display("FAIL pipe_l2 k=%0d act=%b%b/%h exp=%b%b/%h", k, rv0[0], rv1[0], rd_data1[0 +: DW],
                 k < 4, k >= 1 && k <= 4, (k >= 1 && k <= 4) ? mm[1][k-1] : rd_data1[0 +: DW]);
      else passed++;
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] d;
    logic [63:0] alias_word;
    alias_word = mm[1][40];
    idle(); set_port(0, 1'b1, 1'b0, 'hF0, 64'h0, 8'h00); step();
    total++;
    if (rv0[0] !== 1'b1 || ae0[0] !== 1'b0 || rd_data0[0 +: DW] !== mm[0][8'hF0])
      $display("FAIL oor_l1_inrange act=%b%b/%h exp=10/%h", rv0[0], ae0[0], rd_data0[0 +: DW], mm[0][8'hF0]);
    else passed++;
    idle(); step();
    total++;
    if (rv1[0] !== 1'b1 || ae1[0] !== 1'b1 || rd_data1[0 +: DW] !== 64'h0)
      $display("FAIL oor_read act=%b%b/%h exp=11/0", rv1[0], ae1[0], rd_data1[0 +: DW]);
    else passed++;
    d = {$urandom, $urandom};
    idle(); set_port(0, 1'b0, 1'b1, 'hF0, d, 8'hFF); step();
    idle(); step();
    total++;
    if (rv1[0] !== 1'b0 || ae1[0] !== 1'b1) $display("FAIL oor_we_err act=%b%b exp=01", rv1[0], ae1[0]);
    else passed++;
    idle(); set_port(0, 1'b1, 1'b0, 'hF0, 64'h0, 8'h00); set_port(1, 1'b1, 1'b0, 40, 64'h0, 8'h00); step();
    total++;
    if (rd_data0[0 +: DW] !== d) $display("FAIL oor_l1_write act=%h exp=%h", rd_data0[0 +: DW], d);
    else passed++;
    idle(); step();
    total++;
    if (rd_data1[0 +: DW] !== 64'h0 || ae1[0] !== 1'b1 || rd_data1[DW +: DW] !== alias_word)
      $display("FAIL oor_no_change act=%h/%b/%h exp=0/1/%h", rd_data1[0 +: DW], ae1[0], rd_data1[DW +: DW], alias_word);
    else passed++;
  endtask

  task automatic test_rd_during_wr();
    logic [63:0] exp_w;
`ifdef MEM_WR_FWD_EN
    exp_w = 64'hFFFFFFFFFFFFFFFF;
`else
    exp_w = 64'h0;
`endif
    idle(); set_port(0, 1'b0, 1'b1, 'h20, 64'h0, 8'hFF); step();
    idle();
    set_port(0, 1'b0, 1'b1, 'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    set_port(1, 1'b1, 1'b0, 'h20, 64'h0, 8'h00);
    step();
    total++;
    if (rd_data0[DW +: DW] !== exp_w) $display("FAIL rdw_l1 act=%h exp=%h", rd_data0[DW +: DW], exp_w);
    else passed++;
    idle(); step();
    total++;
    if (rd_data1[DW +: DW] !== exp_w) $display("FAIL rdw_l2 act=%h exp=%h", rd_data1[DW +: DW], exp_w);
    else passed++;
  endtask

  task automatic test_reset_midflight();
    logic [63:0] keep;
    keep = mm[0][8'h30];
    idle(); set_port(0, 1'b1, 1'b0, 3, 64'h0, 8'h00); step();
    idle(); rst = 1'b1; set_port(1, 1'b0, 1'b1, 'h30, 64'hDEADBEEFCAFEF00D, 8'hFF); step();
    total++;
    if ({rv0, ae0, coll0, rd_data0, rv1, ae1, coll1, rd_data1} !== '0)
      $display("FAIL rst_mid_zero act=%b%b/%h exp=all0", rv1, ae1, rd_data1[0 +: DW]);
    else passed++;
    rst = 1'b0; idle(); step();
    total++;
    if (rv1 !== 2'b00 || rv0 !== 2'b00) $display("FAIL rst_mid_drop act=%b%b exp=0000", rv0, rv1);
    else passed++;
    idle(); set_port(1, 1'b1, 1'b0, 'h30, 64'h0, 8'h00); step();
    total++;
    if (rd_data0[DW +: DW] !== keep) $display("FAIL rst_mid_wr act=%h exp=%h", rd_data0[DW +: DW], keep);
    else passed++;
    idle(); step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle();
      rst = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < NP; p++)
        set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 1) ? 196 + $urandom_range(0, 7) : $urandom_range(0, 255),
                 {$urandom, $urandom}, 8'($urandom));
      step();
      total++;
      if ({rv0, ae0, coll0, rd_data0} !== {ev[0], ee[0], ec[0], ed[0][1], ed[0][0]})
        $display("FAIL rand_l1 cyc=%0d act=%h exp=%h", i, {rv0, ae0, coll0, rd_data0}, {ev[0], ee[0], ec[0], ed[0][1], ed[0][0]});
      else passed++;
      total++;
      if ({rv1, ae1, coll1, rd_data1} !== {ev[1], ee[1], ec[1], ed[1][1], ed[1][0]})
        $display("FAIL rand_l2 cyc=%0d act=%h exp=%h", i, {rv1, ae1, coll1, rd_data1}, {ev[1], ee[1], ec[1], ed[1][1], ed[1][0]});
      else passed++;
    end
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    test_reset();
    rst = 1'b0;
    preload();
    test_write_read();
    test_collision();
    test_pipelined();
    test_out_of_range();
    test_rd_during_wr();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
